// File: rtl/dvp_apb_master.sv
// dvp_apb_master: single-outstanding APB initiator for the DVP register slave.
// Command in, SETUP/ACCESS sequencing with bounded PREADY wait, response out.
module dvp_apb_master #(
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] io_ahb_PADDR,
  output logic              io_ahb_PSEL,
  output logic              io_ahb_PENABLE,
  output logic              io_ahb_PWRITE,
  output logic [31:0]       io_ahb_PWDATA,
  input  logic              io_ahb_PREADY,
  input  logic [31:0]       io_ahb_PRDATA,
  input  logic              io_ahb_PSLVERROR
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              to_hit;
  logic              psel_q;
  logic              pen_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [31:0]       pwdata_q;
  logic              rvld_q;
  logic [31:0]       rdata_q;
  logic              rerr_q;
  logic              rto_q;

  assign cmd_ready = (state_q == IDLE);
  assign cnt_d     = cnt_q + CNT_W'(1);
  // TIMEOUT of 0 never fires, so the wait is unbounded
  assign to_hit    = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rvld_q   <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      rto_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            psel_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          pen_q   <= 1'b1;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (!io_ahb_PREADY) begin
            cnt_q <= cnt_d;
          end
          if (io_ahb_PREADY) begin
            rdata_q <= pwrite_q ? 32'h0 : io_ahb_PRDATA;
            rerr_q  <= io_ahb_PSLVERROR;
            rto_q   <= 1'b0;
            psel_q  <= 1'b0;
            pen_q   <= 1'b0;
            rvld_q  <= 1'b1;
            state_q <= RESP;
          end else if (to_hit) begin
            rdata_q <= 32'h0;
            rerr_q  <= 1'b1;
            rto_q   <= 1'b1;
            psel_q  <= 1'b0;
            pen_q   <= 1'b0;
            rvld_q  <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rvld_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io_ahb_PSEL    = psel_q;
  assign io_ahb_PENABLE = pen_q;
  assign io_ahb_PWRITE  = pwrite_q;
  assign io_ahb_PADDR   = paddr_q;
  assign io_ahb_PWDATA  = pwdata_q;
  assign rsp_valid      = rvld_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_err        = rerr_q;
  assign rsp_timeout    = rto_q;

endmodule
